// File: rtl/neural_pkg.sv
// rtl/neural_pkg.sv - shared types, defaults and width helpers for the sequential neuron MAC
package neural_pkg;

  typedef enum logic {ACC, HOLD} state_t;

  localparam int DEF_LANES      = 10;
  localparam int DEF_DW         = 8;
  localparam int DEF_ACC_W      = 24;
  localparam int DEF_FRAC_SHIFT = 4;
  localparam int DEF_OUT_W      = 8;

  // All intermediate arithmetic is carried in 64 bits; ACC_W must stay below 63.
  typedef logic signed [63:0] wide_t;

  function automatic wide_t ext(input logic [63:0] value, input int width, input bit is_signed);
    logic [63:0] mask;
    logic [63:0] res;
    mask = (64'd1 << width) - 64'd1;
    res  = value & mask;
    if (is_signed && value[6'(width - 1)]) res = res | ~mask;
    return wide_t'(res);
  endfunction

  function automatic wide_t sat(input wide_t value, input int width, input bit is_signed);
    wide_t hi;
    wide_t lo;
    hi = is_signed ? (64'sd1 <<< (width - 1)) - 64'sd1 : (64'sd1 <<< width) - 64'sd1;
    lo = is_signed ? -(64'sd1 <<< (width - 1)) : 64'sd0;
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/neural_lane_dot.sv
// rtl/neural_lane_dot.sv - combinational full-width dot product of one beat
module neural_lane_dot #(
  parameter int LANES  = 10,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  parameter int SUM_W  = 2 * DW + $clog2(LANES) + 1
) (
  input  logic [LANES*DW-1:0]     data,
  input  logic [LANES*DW-1:0]     weight,
  output logic signed [SUM_W-1:0] dot
);

  logic [2*DW-1:0] de, we, prod;

  // Operands are extended to 2*DW first so one truncated multiply serves both signed modes.
  always_comb begin
    de   = '0;
    we   = '0;
    prod = '0;
    dot  = '0;
    for (int i = 0; i < LANES; i++) begin
      de   = (SIGNED != 0) ? {{DW{data[i*DW+DW-1]}}, data[i*DW +: DW]}
                           : {{DW{1'b0}}, data[i*DW +: DW]};
      we   = (SIGNED != 0) ? {{DW{weight[i*DW+DW-1]}}, weight[i*DW +: DW]}
                           : {{DW{1'b0}}, weight[i*DW +: DW]};
      prod = de * we;
      dot  = dot + ((SIGNED != 0) ? SUM_W'($signed(prod)) : SUM_W'(prod));
    end
  end

endmodule

// File: rtl/neural_mac_seq.sv
// rtl/neural_mac_seq.sv - time-multiplexed neuron: beat accumulation, requantise, psum, ReLU, saturate
module neural_mac_seq
  import neural_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int DW         = DEF_DW,
  parameter int SIGNED     = 0,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int RELU       = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [LANES*DW-1:0] in_data,
  input  logic [LANES*DW-1:0] in_weight,
  input  logic [ACC_W-1:0]    bias,
  input  logic                use_psum,
  input  logic [OUT_W-1:0]    psum_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_sat
);

  localparam int SUM_W = 2 * DW + $clog2(LANES) + 1;
  localparam bit SGN   = (SIGNED != 0);

  state_t state, state_next;
  logic [ACC_W-1:0] acc;
  logic frame_open, frame_sat, use_psum_q;
  logic signed [SUM_W-1:0] dot;
  wide_t base, sum, acc_new, r, o;
  logic accept, restart, clamp, sat_new, psum_sel;

  neural_lane_dot #(.LANES(LANES), .DW(DW), .SIGNED(SIGNED), .SUM_W(SUM_W)) u_dot (
    .data   (in_data),
    .weight (in_weight),
    .dot    (dot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  assign accept  = in_valid && in_ready;
  // A beat with no frame open starts one even without in_first.
  assign restart = in_first || !frame_open;

  always_comb begin
    base     = restart ? ext(64'(bias), ACC_W, SGN) : ext(64'(acc), ACC_W, SGN);
    sum      = base + wide_t'(dot);
    acc_new  = sat(sum, ACC_W, SGN);
    clamp    = (acc_new != sum);
    sat_new  = (!restart && frame_sat) || clamp;
    psum_sel = restart ? use_psum : use_psum_q;
    r        = (acc_new >>> FRAC_SHIFT) + (psum_sel ? ext(64'(psum_in), OUT_W, SGN) : 64'sd0);
    if (RELU != 0 && SGN && r < 0) r = 64'sd0;
    o        = sat(r, OUT_W, SGN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      frame_open <= 1'b0;
      frame_sat  <= 1'b0;
      use_psum_q <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
    end else if (accept) begin
      acc        <= acc_new[ACC_W-1:0];
      frame_sat  <= sat_new;
      use_psum_q <= psum_sel;
      frame_open <= !in_last;
      if (in_last) begin
        out_data <= o[OUT_W-1:0];
        out_sat  <= sat_new || (o != r);
      end
    end
  end

endmodule

// File: tb/tb_neural_mac_seq.sv
// tb/tb_neural_mac_seq.sv - scoreboard bench for neural_mac_seq (unsigned, signed+ReLU, signed)
module tb_neural_mac_seq;

  localparam int LANES = 10;
  localparam int DW    = 8;
  localparam int ACC_W = 24;
  localparam int OUT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_valid_u, in_valid_s, in_first, in_last, use_psum, out_ready;
  logic [LANES*DW-1:0] in_data, in_weight;
  logic [ACC_W-1:0] bias;
  logic [OUT_W-1:0] psum_in;
  logic in_ready_u, out_valid_u, out_sat_u;
  logic in_ready_r, out_valid_r, out_sat_r;
  logic in_ready_n, out_valid_n, out_sat_n;
  logic [OUT_W-1:0] out_data_u, out_data_r, out_data_n;

  typedef struct packed {logic [7:0] d; logic s;} exp_t;
  exp_t q_u[$];
  exp_t q_r[$];
  exp_t q_n[$];
  int checks = 0;
  int errors = 0;

  neural_mac_seq #(.SIGNED(0), .RELU(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid_u), .in_ready(in_ready_u), .in_first(in_first),
    .in_last(in_last), .in_data(in_data), .in_weight(in_weight), .bias(bias), .use_psum(use_psum),
    .psum_in(psum_in), .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
    .out_sat(out_sat_u));

  neural_mac_seq #(.SIGNED(1), .RELU(1)) dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_r), .in_first(in_first),
    .in_last(in_last), .in_data(in_data), .in_weight(in_weight), .bias(bias), .use_psum(use_psum),
    .psum_in(psum_in), .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
    .out_sat(out_sat_r));

  neural_mac_seq #(.SIGNED(1), .RELU(0)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_n), .in_first(in_first),
    .in_last(in_last), .in_data(in_data), .in_weight(in_weight), .bias(bias), .use_psum(use_psum),
    .psum_in(psum_in), .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
    .out_sat(out_sat_n));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid_u && out_ready) begin
      if (q_u.size() == 0) check("u_unexpected_output", 1, 0);
      else begin
        e = q_u.pop_front();
        check("u_out_data", out_data_u, e.d);
        check("u_out_sat", out_sat_u, e.s);
      end
    end
    if (!rst && out_valid_r && out_ready) begin
      if (q_r.size() == 0) check("r_unexpected_output", 1, 0);
      else begin
        e = q_r.pop_front();
        check("r_out_data", out_data_r, e.d);
        check("r_out_sat", out_sat_r, e.s);
      end
    end
    if (!rst && out_valid_n && out_ready) begin
      if (q_n.size() == 0) check("n_unexpected_output", 1, 0);
      else begin
        e = q_n.pop_front();
        check("n_out_data", out_data_n, e.d);
        check("n_out_sat", out_sat_n, e.s);
      end
    end
  end

  task automatic lanes(input logic [7:0] d0, input logic [7:0] w0, input logic [7:0] d, input logic [7:0] w);
    for (int i = 0; i < LANES; i++) begin
      in_data[i*DW +: DW]   = (i == 0) ? d0 : d;
      in_weight[i*DW +: DW] = (i == 0) ? w0 : w;
    end
  endtask

  task automatic beat(input bit sel_s, input bit first, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    in_first = first;
    in_last  = last;
    if (sel_s) in_valid_s = 1'b1;
    else       in_valid_u = 1'b1;
    while (!(sel_s ? in_ready_r : in_ready_u) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("beat_accept_timeout", 0, 1);
    else @(posedge clk);
    #1;
    in_valid_u = 1'b0;
    in_valid_s = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid_u = 1'b0; in_valid_s = 1'b0; in_first = 1'b0; in_last = 1'b0;
    use_psum = 1'b0; out_ready = 1'b1; bias = '0; psum_in = '0;
    lanes(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready_u, 1);
    check("reset_out_valid", out_valid_u, 0);
    check("reset_out_data", out_data_u, 0);
    check("reset_out_sat", out_sat_u, 0);
    rst = 1'b0;

    // single beat: 10*2*3=60 -> 3
    lanes(2, 3, 2, 3); q_u.push_back('{8'd3, 1'b0}); beat(0, 1, 1);
    @(negedge clk);
    check("latency_out_valid", out_valid_u, 1);

    // 5 beats of 2560 -> 12800>>4=800 -> saturates
    lanes(16, 16, 16, 16); q_u.push_back('{8'd255, 1'b1});
    beat(0, 1, 0); beat(0, 0, 0); beat(0, 0, 0); beat(0, 0, 0); beat(0, 0, 1);

    // mid-frame in_first discards the open frame
    beat(0, 1, 0);
    lanes(2, 3, 2, 3); q_u.push_back('{8'd3, 1'b0}); beat(0, 1, 1);

    // bias 16: 76>>4=4; no in_first with no open frame loads bias 32: 92>>4=5
    bias = 24'd16; q_u.push_back('{8'd4, 1'b0}); beat(0, 1, 1);
    bias = 24'd32; q_u.push_back('{8'd5, 1'b0}); beat(0, 0, 1);
    bias = '0;

    // psum: 1600>>4=100, +200 -> 255 sat; use_psum taken from first beat
    lanes(40, 40, 0, 0); use_psum = 1'b1; q_u.push_back('{8'd255, 1'b1}); beat(0, 1, 0);
    use_psum = 1'b0; lanes(0, 0, 0, 0); psum_in = 8'd200; beat(0, 0, 1);
    lanes(40, 40, 0, 0); use_psum = 1'b1; psum_in = 8'd50; q_u.push_back('{8'd150, 1'b0}); beat(0, 1, 1);
    use_psum = 1'b0; psum_in = '0;

    // signed: -4*8=-32 -> -2; ReLU clamps to 0
    lanes(8'hFC, 8'd8, 0, 0);
    q_r.push_back('{8'd0, 1'b0}); q_n.push_back('{8'hFE, 1'b0}); beat(1, 1, 1);
    // signed: -2 + (-127) = -129 -> -128 sat; ReLU gives 0
    use_psum = 1'b1; psum_in = 8'h81;
    q_r.push_back('{8'd0, 1'b0}); q_n.push_back('{8'h80, 1'b1}); beat(1, 1, 1);
    use_psum = 1'b0; psum_in = '0;

    // backpressure: result held 4 cycles, waiting beat taken only after handshake
    lanes(2, 3, 2, 3); q_u.push_back('{8'd3, 1'b0}); out_ready = 1'b0; beat(0, 1, 1);
    lanes(4, 4, 4, 4); q_u.push_back('{8'd10, 1'b0});
    @(negedge clk);
    in_first = 1'b1; in_last = 1'b1; in_valid_u = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_out_valid", out_valid_u, 1);
      check("bp_out_data", out_data_u, 3);
      check("bp_in_ready", in_ready_u, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    beat(0, 1, 1);

    // reset after 2 of 5 beats; next frame (no in_first) carries no residue
    lanes(16, 16, 16, 16); beat(0, 1, 0); beat(0, 0, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready_u, 1);
    check("midrst_out_valid", out_valid_u, 0);
    check("midrst_out_data", out_data_u, 0);
    check("midrst_out_sat", out_sat_u, 0);
    rst = 1'b0;
    lanes(2, 3, 2, 3); q_u.push_back('{8'd3, 1'b0}); beat(0, 0, 1);

    for (int i = 0; i < 20 && (q_u.size() + q_r.size() + q_n.size()) != 0; i++) @(negedge clk);
    check("q_u_drained", q_u.size(), 0);
    check("q_r_drained", q_r.size(), 0);
    check("q_n_drained", q_n.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
